link_tx_port: RTL and testbench

- Transmit side of one router port toward an MGT link; pairs with the link's receive-side input queue.
- Accepts flits from one switch output, buffers them, and sends them on the link under credit-based flow control.
- Periodically interleaves credit-return flits that report slots freed in the local input queue back to the upstream neighbour.

---
 rtl/router_pkg.sv | 23 ++
 rtl/tx_skid_fifo.sv | 49 ++++
 rtl/link_tx_port.sv | 134 +++++++++++++
 tb/tb_link_tx_port.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router flit layout, direction codes and tx port state type
package router_pkg;

  localparam int FLIT_SIZE      = 82;
  localparam int VALID_BIT      = 81;
  localparam int CREDIT_BIT     = 80;
  localparam int CNT_W          = 16;
  localparam int CREDIT_FIELD_W = CNT_W;

  localparam logic [2:0] DIR_LOCAL = 3'd0;
  localparam logic [2:0] DIR_NORTH = 3'd1;
  localparam logic [2:0] DIR_EAST  = 3'd2;
  localparam logic [2:0] DIR_SOUTH = 3'd3;
  localparam logic [2:0] DIR_WEST  = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    CREDIT = 2'd2,
    STALL  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tx_skid_fifo.sv
// rtl/tx_skid_fifo.sv - small synchronous FIFO buffering flits ahead of the link
module tx_skid_fifo #(
  parameter int WIDTH = 82,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Extra pointer MSB tells a full buffer from an empty one when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointers advance only on accepted operations; a push into a full buffer is ignored.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_i && !full_o);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_i && !empty_o);
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/link_tx_port.sv
// rtl/link_tx_port.sv - router port transmitter with credit flow control and credit return
module link_tx_port #(
  parameter int FLIT_SIZE          = 82,
  parameter int FIFO_DEPTH         = 4,
  parameter int CREDIT_INIT        = 160,
  parameter int CREDIT_BACK_PERIOD = 100,
  parameter int CNT_W              = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] in_flit,
  input  logic                 in_valid,
  output logic                 in_avail,
  input  logic                 credit_in_valid,
  input  logic [CNT_W-1:0]     credit_in_count,
  input  logic                 slot_freed,
  output logic [FLIT_SIZE-1:0] out_flit,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     credit_cnt,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 credit_ovf
);

  import router_pkg::*;

  localparam int               PER_W      = (CREDIT_BACK_PERIOD > 1) ? $clog2(CREDIT_BACK_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(CREDIT_BACK_PERIOD - 1);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W+1)'(CREDIT_INIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  tx_state_t            state_q, state_d;
  logic [FLIT_SIZE-1:0] out_flit_q, out_flit_d;
  logic [CNT_W-1:0]     credit_q, credit_d;
  logic [CNT_W-1:0]     stall_q, stall_d;
  logic [CNT_W-1:0]     pending_q, pending_d;
  logic [PER_W-1:0]     period_q, period_d;
  logic                 credit_req_q, credit_req_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_W:0]       credit_sum;
  logic                 wrap;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FLIT_SIZE-1:0] fifo_head;

  assign in_avail   = !fifo_full;
  assign fifo_push  = in_valid && !fifo_full;
  assign fifo_pop   = (state_d == DATA);
  assign wrap       = (period_q == PER_LAST);
  assign out_flit   = out_flit_q;
  assign out_valid  = (state_q == DATA) || (state_q == CREDIT);
  assign credit_cnt = credit_q;
  assign stall_cnt  = stall_q;
  assign credit_ovf = ovf_q;

  tx_skid_fifo #(
    .WIDTH (FLIT_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (fifo_push),
    .push_data_i (in_flit),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Per-cycle send decision (credit return beats data) and all counter next-state.
  always_comb begin
    state_d      = IDLE;
    out_flit_d   = out_flit_q;
    stall_d      = stall_q;
    pending_d    = pending_q;
    credit_req_d = credit_req_q;
    ovf_d        = ovf_q;
    period_d     = wrap ? '0 : period_q + PER_W'(1);

    if (credit_req_q)     state_d = CREDIT;
    else if (!fifo_empty) state_d = (credit_q != '0) ? DATA : STALL;

    case (state_d)
      CREDIT: begin
        out_flit_d                        = '0;
        out_flit_d[VALID_BIT]             = 1'b1;
        out_flit_d[CREDIT_BIT]            = 1'b1;
        out_flit_d[CREDIT_FIELD_W-1:0]    = pending_q;
        credit_req_d                      = 1'b0;
      end
      DATA:    out_flit_d = fifo_head;
      STALL:   if (stall_q != CNT_MAX) stall_d = stall_q + CNT_W'(1);
      default: ;
    endcase

    // The reported count restarts from this cycle's pulse so no freed slot is dropped.
    if (state_d == CREDIT)                        pending_d = CNT_W'(slot_freed);
    else if (slot_freed && pending_q != CNT_MAX)  pending_d = pending_q + CNT_W'(1);

    if (wrap && (pending_q != '0) && (state_d != CREDIT)) credit_req_d = 1'b1;

    // One extra bit lets an oversized return be detected before clamping.
    credit_sum = {1'b0, credit_q} - (CNT_W+1)'(state_d == DATA)
               + (credit_in_valid ? {1'b0, credit_in_count} : '0);
    if (credit_sum > CREDIT_MAX) begin
      credit_d = CREDIT_MAX[CNT_W-1:0];
      ovf_d    = 1'b1;
    end else begin
      credit_d = credit_sum[CNT_W-1:0];
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      out_flit_q   <= '0;
      credit_q     <= CREDIT_MAX[CNT_W-1:0];
      stall_q      <= '0;
      pending_q    <= '0;
      period_q     <= '0;
      credit_req_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_flit_q   <= out_flit_d;
      credit_q     <= credit_d;
      stall_q      <= stall_d;
      pending_q    <= pending_d;
      period_q     <= period_d;
      credit_req_q <= credit_req_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_link_tx_port.sv
// tb/tb_link_tx_port.sv - scoreboard bench for link_tx_port
module tb_link_tx_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [81:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_avail;
  logic        credit_in_valid = 1'b0;
  logic [15:0] credit_in_count = '0;
  logic        slot_freed = 1'b0;
  logic [81:0] out_flit;
  logic        out_valid;
  logic [15:0] credit_cnt;
  logic [15:0] stall_cnt;
  logic        credit_ovf;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [81:0] dq[$];
  logic [81:0] cq[$];

  link_tx_port #(
    .CREDIT_BACK_PERIOD (10)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_flit         (in_flit),
    .in_valid        (in_valid),
    .in_avail        (in_avail),
    .credit_in_valid (credit_in_valid),
    .credit_in_count (credit_in_count),
    .slot_freed      (slot_freed),
    .out_flit        (out_flit),
    .out_valid       (out_valid),
    .credit_cnt      (credit_cnt),
    .stall_cnt       (stall_cnt),
    .credit_ovf      (credit_ovf)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; equals the DUT period counter phase modulo 10.
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input bit ok, input string nm, input logic [81:0] act, input logic [81:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [81:0] mk_data(input int id);
    logic [15:0] idw;
    idw = 16'(id);
    return {1'b1, 1'b0, 16'hCAFE, 48'h0, idw};
  endfunction

  function automatic logic [81:0] mk_credit(input int n);
    logic [15:0] nw;
    nw = 16'(n);
    return {1'b1, 1'b1, 64'h0, nw};
  endfunction

  task automatic push_flit(input logic [81:0] d);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_flit  = d;
    while (!in_avail && k < 20) begin
      tick();
      k++;
    end
    check(in_avail, "push_accept", 82'(in_avail), 82'(1));
    if (in_avail) dq.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: every presented flit is matched against the proper expected queue.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (out_flit[80]) begin
        if (cq.size() == 0) check(1'b0, "credit_flit_unexpected", out_flit, 82'(0));
        else begin
          logic [81:0] e;
          e = cq.pop_front();
          check(out_flit == e, "credit_flit", out_flit, e);
        end
      end else begin
        if (dq.size() == 0) check(1'b0, "data_flit_unexpected", out_flit, 82'(0));
        else begin
          logic [81:0] e;
          e = dq.pop_front();
          check(out_flit == e, "data_flit", out_flit, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state
    tick();
    tick();
    check(out_valid == 1'b0, "rst_out_valid", 82'(out_valid), 82'(0));
    check(out_flit == '0, "rst_out_flit", out_flit, 82'(0));
    check(in_avail == 1'b1, "rst_in_avail", 82'(in_avail), 82'(1));
    check(credit_cnt == 16'd160, "rst_credit", 82'(credit_cnt), 82'(160));
    check(stall_cnt == 16'd0, "rst_stall", 82'(stall_cnt), 82'(0));
    check(credit_ovf == 1'b0, "rst_ovf", 82'(credit_ovf), 82'(0));
    rst = 1'b1;
    tick();

    // Three back-to-back flits; first output one cycle after first accept
    push_flit(mk_data(1));
    check(out_valid == 1'b0, "latency_same_edge", 82'(out_valid), 82'(0));
    push_flit(mk_data(2));
    check(out_valid == 1'b1, "latency_next_edge", 82'(out_valid), 82'(1));
    push_flit(mk_data(3));
    repeat (3) tick();
    check(credit_cnt == 16'd157, "credit_after_3", 82'(credit_cnt), 82'(157));

    // Drain credits down to 2
    for (int i = 0; i < 155; i++) push_flit(mk_data(100 + i));
    repeat (3) tick();
    check(credit_cnt == 16'd2, "credit_drained_to_2", 82'(credit_cnt), 82'(2));

    // Four flits with two credits: two sent, then stall
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_flit  = mk_data(300 + i);
      if (i < 3) dq.push_back(mk_data(300 + i));
      check(in_avail, "push_accept", 82'(in_avail), 82'(1));
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check(credit_cnt == 16'd0, "credit_zero", 82'(credit_cnt), 82'(0));
    check(stall_cnt == 16'd5, "stall_cnt_5", 82'(stall_cnt), 82'(5));
    repeat (5) tick();
    check(stall_cnt == 16'd10, "stall_cnt_10", 82'(stall_cnt), 82'(10));
    check(out_valid == 1'b0, "stalled_no_output", 82'(out_valid), 82'(0));
    credit_in_valid = 1'b1;
    credit_in_count = 16'd1;
    tick();
    credit_in_valid = 1'b0;
    repeat (4) tick();
    check(credit_cnt == 16'd0, "credit_after_return1", 82'(credit_cnt), 82'(0));
    dq.push_back(mk_data(303));

    // Credit return while data is stalled: five pulses, then a same-cycle pulse
    while (cyc % 10 != 1) tick();
    slot_freed = 1'b1;
    repeat (5) tick();
    slot_freed = 1'b0;
    cq.push_back(mk_credit(5));
    cq.push_back(mk_credit(1));
    while (cyc % 10 != 0) tick();
    slot_freed = 1'b1;
    tick();
    slot_freed = 1'b0;
    repeat (14) tick();
    check(cq.size() == 0, "credit_flits_seen", 82'(cq.size()), 82'(0));
    check(credit_cnt == 16'd0, "credit_flit_no_consume", 82'(credit_cnt), 82'(0));

    // Fill the stalled FIFO; fifth flit waits for the first pop
    for (int i = 1; i <= 3; i++) push_flit(mk_data(400 + i));
    check(in_avail == 1'b0, "full_in_avail", 82'(in_avail), 82'(0));
    in_valid = 1'b1;
    in_flit  = mk_data(404);
    repeat (3) tick();
    check(in_avail == 1'b0, "full_held", 82'(in_avail), 82'(0));
    credit_in_valid = 1'b1;
    credit_in_count = 16'd1;
    tick();
    credit_in_valid = 1'b0;
    k = 0;
    while (!in_avail && k < 10) begin
      tick();
      k++;
    end
    check(in_avail, "fifth_accepted", 82'(in_avail), 82'(1));
    if (in_avail) dq.push_back(mk_data(404));
    tick();
    in_valid = 1'b0;
    check(in_avail == 1'b0, "full_again", 82'(in_avail), 82'(0));

    // Reset mid-stream with a flit on the wire and three queued
    credit_in_valid = 1'b1;
    credit_in_count = 16'd1;
    tick();
    credit_in_valid = 1'b0;
    tick();
    check(out_valid == 1'b1, "pre_reset_valid", 82'(out_valid), 82'(1));
    rst = 1'b0;
    dq.delete();
    #1;
    check(out_valid == 1'b0, "async_reset_valid", 82'(out_valid), 82'(0));
    check(out_flit == '0, "async_reset_flit", out_flit, 82'(0));
    tick();
    check(credit_cnt == 16'd160, "reset_credit", 82'(credit_cnt), 82'(160));
    check(in_avail == 1'b1, "reset_fifo_empty", 82'(in_avail), 82'(1));
    check(stall_cnt == 16'd0, "reset_stall", 82'(stall_cnt), 82'(0));
    rst = 1'b1;
    repeat (10) tick();

    // Simultaneous send and return clamps and sets sticky overflow
    push_flit(mk_data(500));
    repeat (2) tick();
    check(credit_cnt == 16'd159, "credit_159", 82'(credit_cnt), 82'(159));
    check(credit_ovf == 1'b0, "ovf_clear", 82'(credit_ovf), 82'(0));
    push_flit(mk_data(501));
    credit_in_valid = 1'b1;
    credit_in_count = 16'd3;
    tick();
    credit_in_valid = 1'b0;
    check(credit_cnt == 16'd160, "credit_clamped", 82'(credit_cnt), 82'(160));
    check(credit_ovf == 1'b1, "ovf_set", 82'(credit_ovf), 82'(1));
    repeat (5) tick();
    check(credit_ovf == 1'b1, "ovf_sticky", 82'(credit_ovf), 82'(1));

    repeat (3) tick();
    check(dq.size() == 0, "data_queue_empty", 82'(dq.size()), 82'(0));
    check(cq.size() == 0, "credit_queue_empty", 82'(cq.size()), 82'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
